// File: rtl/jpeg_dezigzag_dequant.sv
// JPEG de-zigzag and dequantization stage.
// Zigzag-ordered quantized coefficients arrive one per accepted beat. Each beat
// is multiplied by the Annex K quantizer for its natural position, saturated to
// DATA_WIDTH, and stored in raster order. After the 64th beat or an EOB beat the
// whole 8x8 block is presented on out_block until downstream accepts it.
//
// state | meaning
// ------+-----------------------------------------------------------
// FILL  | accepting coefficients, in_ready=1, k counts accepted beats
// HOLD  | block complete, out_valid=1, waiting for out_ready
module jpeg_dezigzag_dequant #(
   parameter int DATA_WIDTH = 32,
   parameter int USE_LUMA   = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [DATA_WIDTH-1:0]   in_coef,
   input  logic                           in_eob,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic        [DATA_WIDTH*64-1:0] out_block
);

   localparam int PW = DATA_WIDTH + 9;

   // Natural (row*8+col) position of the k-th zigzag coefficient.
   localparam logic [5:0] ZZ [64] = '{
       0,  1,  8, 16,  9,  2,  3, 10,
      17, 24, 32, 25, 18, 11,  4,  5,
      12, 19, 26, 33, 40, 48, 41, 34,
      27, 20, 13,  6,  7, 14, 21, 28,
      35, 42, 49, 56, 57, 50, 43, 36,
      29, 22, 15, 23, 30, 37, 44, 51,
      58, 59, 52, 45, 38, 31, 39, 46,
      53, 60, 61, 54, 47, 55, 62, 63
   };

   // Annex K luminance quantizer, natural order.
   localparam logic [7:0] LUMA_Q [64] = '{
      16, 11, 10, 16,  24,  40,  51,  61,
      12, 12, 14, 19,  26,  58,  60,  55,
      14, 13, 16, 24,  40,  57,  69,  56,
      14, 17, 22, 29,  51,  87,  80,  62,
      18, 22, 37, 56,  68, 109, 103,  77,
      24, 35, 55, 64,  81, 104, 113,  92,
      49, 64, 78, 87, 103, 121, 120, 101,
      72, 92, 95, 98, 112, 100, 103,  99
   };

   // Annex K chrominance quantizer, natural order.
   localparam logic [7:0] CHROMA_Q [64] = '{
      17, 18, 24, 47, 99, 99, 99, 99,
      18, 21, 26, 66, 99, 99, 99, 99,
      24, 26, 56, 99, 99, 99, 99, 99,
      47, 66, 99, 99, 99, 99, 99, 99,
      99, 99, 99, 99, 99, 99, 99, 99,
      99, 99, 99, 99, 99, 99, 99, 99,
      99, 99, 99, 99, 99, 99, 99, 99,
      99, 99, 99, 99, 99, 99, 99, 99
   };

   localparam logic signed [PW-1:0] SAT_MAX = {{10{1'b0}}, {(DATA_WIDTH-1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_MIN = {{10{1'b1}}, {(DATA_WIDTH-1){1'b0}}};

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t                         state;
   logic        [5:0]              k;
   logic signed [DATA_WIDTH-1:0]   coef_buf [64];

   logic        [5:0]              nat_pos;
   logic        [7:0]              q_sel;
   logic signed [PW-1:0]           prod;
   logic signed [DATA_WIDTH-1:0]   sat_val;

   // Quantizer lookup for the current beat and saturating multiply.
   always_comb begin
      nat_pos = ZZ[k];
      q_sel   = (USE_LUMA != 0) ? LUMA_Q[nat_pos] : CHROMA_Q[nat_pos];
      prod    = in_coef * $signed({1'b0, q_sel});
      if (prod > SAT_MAX) begin
         sat_val = SAT_MAX[DATA_WIDTH-1:0];
      end else if (prod < SAT_MIN) begin
         sat_val = SAT_MIN[DATA_WIDTH-1:0];
      end else begin
         sat_val = prod[DATA_WIDTH-1:0];
      end
   end

   // Block FSM: fill buffer in FILL, present it in HOLD, clear on handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= FILL;
         k         <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         for (int i = 0; i < 64; i++) coef_buf[i] <= '0;
      end else begin
         case (state)
            FILL: begin
               if (in_valid) begin
                  coef_buf[nat_pos] <= sat_val;
                  if (k == 6'd63 || in_eob) begin
                     state     <= HOLD;
                     k         <= '0;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     k <= k + 6'd1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  state     <= FILL;
                  k         <= '0;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  for (int i = 0; i < 64; i++) coef_buf[i] <= '0;
               end
            end
            default: begin
               state     <= FILL;
               k         <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   // Flatten the buffer onto the raster-ordered output bus.
   for (genvar g = 0; g < 64; g++) begin : g_out
      assign out_block[DATA_WIDTH*g +: DATA_WIDTH] = coef_buf[g];
   end

endmodule

// File: tb/tb_jpeg_dezigzag_dequant.sv
// Directed bench for jpeg_dezigzag_dequant: luma, chroma and 16-bit instances.
module tb_jpeg_dezigzag_dequant;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // Luma, 32-bit instance
   logic               l_in_valid = 0, l_in_eob = 0, l_out_ready = 0;
   logic signed [31:0] l_in_coef = 0;
   logic               l_in_ready, l_out_valid;
   logic [32*64-1:0]   l_out_block;
   // Chroma, 32-bit instance
   logic               c_in_valid = 0, c_in_eob = 0, c_out_ready = 0;
   logic signed [31:0] c_in_coef = 0;
   logic               c_in_ready, c_out_valid;
   logic [32*64-1:0]   c_out_block;
   // Luma, 16-bit instance for saturation
   logic               s_in_valid = 0, s_in_eob = 0, s_out_ready = 0;
   logic signed [15:0] s_in_coef = 0;
   logic               s_in_ready, s_out_valid;
   logic [16*64-1:0]   s_out_block;

   jpeg_dezigzag_dequant #(.DATA_WIDTH(32), .USE_LUMA(1)) u_luma (
      .clk(clk), .reset(reset),
      .in_valid(l_in_valid), .in_ready(l_in_ready), .in_coef(l_in_coef), .in_eob(l_in_eob),
      .out_valid(l_out_valid), .out_ready(l_out_ready), .out_block(l_out_block));

   jpeg_dezigzag_dequant #(.DATA_WIDTH(32), .USE_LUMA(0)) u_chroma (
      .clk(clk), .reset(reset),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_coef(c_in_coef), .in_eob(c_in_eob),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_block(c_out_block));

   jpeg_dezigzag_dequant #(.DATA_WIDTH(16), .USE_LUMA(1)) u_sat (
      .clk(clk), .reset(reset),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_coef(s_in_coef), .in_eob(s_in_eob),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_block(s_out_block));

   int checks = 0;
   int failures = 0;

   int luma_q [64] = '{
      16, 11, 10, 16,  24,  40,  51,  61,
      12, 12, 14, 19,  26,  58,  60,  55,
      14, 13, 16, 24,  40,  57,  69,  56,
      14, 17, 22, 29,  51,  87,  80,  62,
      18, 22, 37, 56,  68, 109, 103,  77,
      24, 35, 55, 64,  81, 104, 113,  92,
      49, 64, 78, 87, 103, 121, 120, 101,
      72, 92, 95, 98, 112, 100, 103,  99};
   int zz [64];

   // Zigzag order generated by walking the anti-diagonals.
   task automatic build_zigzag();
      int r, c;
      r = 0; c = 0;
      for (int i = 0; i < 64; i++) begin
         zz[i] = r * 8 + c;
         if (((r + c) % 2) == 0) begin
            if (c == 7) r++;
            else if (r == 0) c++;
            else begin r--; c++; end
         end else begin
            if (r == 7) c++;
            else if (c == 0) r++;
            else begin r++; c--; end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic signed [31:0] l_elem(input int i);
      return l_out_block[32*i +: 32];
   endfunction

   function automatic logic signed [31:0] c_elem(input int i);
      return c_out_block[32*i +: 32];
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      checks++;
      if (l_in_ready !== 1'b1 || c_in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_ready got l=%b c=%b s=%b want 1", l_in_ready, c_in_ready, s_in_ready);
      end
      checks++;
      if (l_out_valid !== 1'b0 || c_out_valid !== 1'b0 || s_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_out_valid got l=%b c=%b s=%b want 0", l_out_valid, c_out_valid, s_out_valid);
      end
      checks++;
      if (l_out_block !== '0 || c_out_block !== '0 || s_out_block !== '0) begin
         failures++;
         $display("FAIL reset_block_zero got nonzero want all zero");
      end
   endtask

   task automatic test_full_luma();
      int bad;
      bad = 0;
      for (int k = 0; k < 64; k++) begin
         l_in_valid = 1'b1; l_in_coef = 1; l_in_eob = 1'b0;
         tick();
         if (k < 63 && l_out_valid !== 1'b0) bad++;
      end
      l_in_valid = 1'b0;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL luma_early_valid got %0d early cycles want 0", bad);
      end
      checks++;
      if (l_out_valid !== 1'b1 || l_in_ready !== 1'b0) begin
         failures++;
         $display("FAIL luma_valid_latency got valid=%b ready=%b want 1/0", l_out_valid, l_in_ready);
      end
      checks++;
      if (l_elem(0) !== 16 || l_elem(1) !== 11 || l_elem(8) !== 12 || l_elem(63) !== 99) begin
         failures++;
         $display("FAIL luma_elems got %0d %0d %0d %0d want 16 11 12 99",
                  l_elem(0), l_elem(1), l_elem(8), l_elem(63));
      end
      bad = 0;
      for (int i = 0; i < 64; i++) if (l_elem(i) !== luma_q[i]) bad++;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL luma_all_elems got %0d wrong want 0", bad);
      end
   endtask

   task automatic test_backpressure();
      logic [32*64-1:0] snap;
      int bad;
      snap = l_out_block;
      bad = 0;
      l_out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         l_in_valid = (i % 2 == 0); l_in_coef = 5;
         tick();
         if (l_out_block !== snap || l_out_valid !== 1'b1 || l_in_ready !== 1'b0) bad++;
      end
      l_in_valid = 1'b0;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL bp_hold_stable got %0d unstable cycles want 0", bad);
      end
      l_out_ready = 1'b1;
      tick();
      l_out_ready = 1'b0;
      checks++;
      if (l_in_ready !== 1'b1 || l_out_valid !== 1'b0 || l_out_block !== '0) begin
         failures++;
         $display("FAIL bp_release got ready=%b valid=%b want 1/0 and zero block", l_in_ready, l_out_valid);
      end
      // single EOB beat: must land at position 0 with the rest still zero
      l_in_valid = 1'b1; l_in_coef = 3; l_in_eob = 1'b1;
      tick();
      l_in_valid = 1'b0; l_in_eob = 1'b0;
      bad = 0;
      for (int i = 1; i < 64; i++) if (l_elem(i) !== 0) bad++;
      checks++;
      if (l_out_valid !== 1'b1 || l_elem(0) !== 48 || bad != 0) begin
         failures++;
         $display("FAIL bp_next_block got valid=%b e0=%0d nonzero=%0d want 1 48 0",
                  l_out_valid, l_elem(0), bad);
      end
      l_out_ready = 1'b1;
      tick();
      l_out_ready = 1'b0;
   endtask

   task automatic test_zigzag_map();
      int bad;
      bad = 0;
      for (int k = 0; k < 64; k++) begin
         l_in_valid = 1'b1; l_in_coef = k + 1; l_in_eob = 1'b0;
         tick();
      end
      l_in_valid = 1'b0;
      for (int k = 0; k < 64; k++)
         if (l_elem(zz[k]) !== (k + 1) * luma_q[zz[k]]) bad++;
      checks++;
      if (l_out_valid !== 1'b1 || bad != 0) begin
         failures++;
         $display("FAIL zigzag_map got valid=%b wrong=%0d want 1 0", l_out_valid, bad);
      end
      l_out_ready = 1'b1;
      tick();
      l_out_ready = 1'b0;
   endtask

   task automatic test_early_eob_chroma();
      int bad;
      c_out_ready = 1'b1;
      c_in_valid = 1'b1; c_in_coef = 5; c_in_eob = 1'b0;
      tick();
      c_in_valid = 1'b0; c_in_coef = 77; c_in_eob = 1'b1;
      tick();
      checks++;
      if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1 || c_elem(0) !== 85) begin
         failures++;
         $display("FAIL chroma_idle got valid=%b ready=%b e0=%0d want 0 1 85", c_out_valid, c_in_ready, c_elem(0));
      end
      c_in_valid = 1'b1; c_in_coef = -2; c_in_eob = 1'b1;
      tick();
      c_in_valid = 1'b0; c_in_eob = 1'b0;
      bad = 0;
      for (int i = 2; i < 64; i++) if (c_elem(i) !== 0) bad++;
      checks++;
      if (c_out_valid !== 1'b1 || c_elem(0) !== 85 || c_elem(1) !== -36 || bad != 0) begin
         failures++;
         $display("FAIL chroma_eob got valid=%b e0=%0d e1=%0d nonzero=%0d want 1 85 -36 0",
                  c_out_valid, c_elem(0), c_elem(1), bad);
      end
      tick();
      c_out_ready = 1'b0;
      checks++;
      if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1 || c_out_block !== '0) begin
         failures++;
         $display("FAIL chroma_handshake got valid=%b ready=%b want 0 1", c_out_valid, c_in_ready);
      end
   endtask

   task automatic test_reset_in_hold();
      c_in_valid = 1'b1; c_in_coef = 4; c_in_eob = 1'b1;
      tick();
      c_in_valid = 1'b0; c_in_eob = 1'b0;
      checks++;
      if (c_out_valid !== 1'b1 || c_elem(0) !== 68) begin
         failures++;
         $display("FAIL hold_before_reset got valid=%b e0=%0d want 1 68", c_out_valid, c_elem(0));
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1 || c_out_block !== '0) begin
         failures++;
         $display("FAIL reset_in_hold got valid=%b ready=%b want 0 1 and zero block", c_out_valid, c_in_ready);
      end
   endtask

   task automatic test_saturation();
      s_out_ready = 1'b0;
      s_in_valid = 1'b1; s_in_coef = 16'sh7FFF; s_in_eob = 1'b0;
      tick();
      s_in_coef = 16'sh8000; s_in_eob = 1'b1;
      tick();
      s_in_valid = 1'b0; s_in_eob = 1'b0;
      checks++;
      if (s_out_valid !== 1'b1 || s_out_block[15:0] !== 16'h7FFF || s_out_block[31:16] !== 16'h8000) begin
         failures++;
         $display("FAIL saturation got valid=%b e0=%h e1=%h want 1 7fff 8000",
                  s_out_valid, s_out_block[15:0], s_out_block[31:16]);
      end
      s_out_ready = 1'b1;
      tick();
      s_out_ready = 1'b0;
      s_in_valid = 1'b1; s_in_coef = -16'sd3; s_in_eob = 1'b1;
      tick();
      s_in_valid = 1'b0; s_in_eob = 1'b0;
      checks++;
      if (s_out_block[15:0] !== 16'hFFD0 || s_out_block[31:16] !== 16'h0000) begin
         failures++;
         $display("FAIL sat_inrange got e0=%h e1=%h want ffd0 0000", s_out_block[15:0], s_out_block[31:16]);
      end
   endtask

   task automatic test_reset_mid_block();
      int bad;
      int early;
      for (int k = 0; k < 30; k++) begin
         l_in_valid = 1'b1; l_in_coef = 7; l_in_eob = 1'b0;
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      early = 0;
      for (int k = 0; k < 64; k++) begin
         l_in_valid = 1'b1; l_in_coef = 2; l_in_eob = 1'b0;
         tick();
         if (k < 63 && l_out_valid !== 1'b0) early++;
      end
      l_in_valid = 1'b0;
      checks++;
      if (early != 0) begin
         failures++;
         $display("FAIL reset_mid_early got %0d early valid cycles want 0", early);
      end
      bad = 0;
      for (int i = 0; i < 64; i++) if (l_elem(i) !== 2 * luma_q[i]) bad++;
      checks++;
      if (l_out_valid !== 1'b1 || l_elem(0) !== 32 || bad != 0) begin
         failures++;
         $display("FAIL reset_mid_block got valid=%b e0=%0d wrong=%0d want 1 32 0",
                  l_out_valid, l_elem(0), bad);
      end
      l_out_ready = 1'b1;
      tick();
      l_out_ready = 1'b0;
   endtask

   initial begin
      build_zigzag();
      test_reset();
      test_full_luma();
      test_backpressure();
      test_zigzag_map();
      test_early_eob_chroma();
      test_reset_in_hold();
      test_saturation();
      test_reset_mid_block();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
